// File: rtl/mvm_stream_driver_if.sv
// Stream link between the host-side driver and the 3x3 multiplier.
// Input beats carry W/x elements; output beats return row results.
interface mvm_stream_driver_if #(
  parameter int WIDTH     = 14,
  parameter int OUT_WIDTH = 28
);
  logic                        in_valid;
  logic                        in_ready;
  logic signed [WIDTH-1:0]     in_data;
  logic                        new_matrix;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [OUT_WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, new_matrix, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, new_matrix, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/mvm_stream_driver.sv
// Host-side initiator: streams W (optional) then x to the multiplier
// and gathers the three row results into a readable register file.
module mvm_stream_driver #(
  parameter int WIDTH     = 14,
  parameter int OUT_WIDTH = 28,
  parameter int SIZE_X    = 3,
  parameter int SIZE_W    = 9
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cfg_wr_en_i,
  input  logic                        cfg_sel_i,
  input  logic [3:0]                  cfg_addr_i,
  input  logic signed [WIDTH-1:0]     cfg_data_i,
  input  logic                        start_i,
  input  logic                        reuse_w_i,
  output logic                        busy_o,
  output logic                        done_o,
  input  logic [1:0]                  res_addr_i,
  output logic signed [OUT_WIDTH-1:0] res_data_o,
  mvm_stream_driver_if.master         mvm
);
  localparam int WI = $clog2(SIZE_W);
  localparam int XI = $clog2(SIZE_X);
  localparam logic [WI-1:0] W_LAST = WI'(SIZE_W - 1);
  localparam logic [XI-1:0] X_LAST = XI'(SIZE_X - 1);

  typedef enum logic [2:0] {
    IDLE, SEND_W, SEND_X, COLLECT, DONE
  } state_e;

  state_e                      state_q, state_d;
  logic [WI-1:0]               widx_q, widx_d;
  logic [XI-1:0]               xidx_q, xidx_d;
  logic [XI-1:0]               ridx_q, ridx_d;
  logic                        w_sent_q, w_sent_d;
  logic                        guard_q, guard_d;
  logic signed [WIDTH-1:0]     w_buf_q [SIZE_W];
  logic signed [WIDTH-1:0]     x_buf_q [SIZE_X];
  logic signed [OUT_WIDTH-1:0] res_q   [SIZE_X];
  logic                        in_fire, out_fire;

  assign busy_o = (state_q == SEND_W) ||
                  (state_q == SEND_X) ||
                  (state_q == COLLECT);
  assign done_o = (state_q == DONE);

  assign mvm.in_valid   = (state_q == SEND_W) ||
                          (state_q == SEND_X);
  assign mvm.new_matrix = (state_q == SEND_W);
  // Ready drops for one cycle after each capture so a lagging valid
  // from the peer cannot be taken twice.
  assign mvm.out_ready  = (state_q == COLLECT) && !guard_q;

  assign in_fire  = mvm.in_valid && mvm.in_ready;
  assign out_fire = mvm.out_valid && mvm.out_ready;

  always_comb begin
    mvm.in_data = '0;
    unique case (state_q)
      SEND_W:  mvm.in_data = w_buf_q[widx_q];
      SEND_X:  mvm.in_data = x_buf_q[xidx_q];
      default: mvm.in_data = '0;
    endcase
  end

  always_comb begin
    res_data_o = '0;
    unique case (res_addr_i)
      2'd0:    res_data_o = res_q[0];
      2'd1:    res_data_o = res_q[1];
      2'd2:    res_data_o = res_q[2];
      default: res_data_o = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    widx_d   = widx_q;
    xidx_d   = xidx_q;
    ridx_d   = ridx_q;
    w_sent_d = w_sent_q;
    guard_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (!reuse_w_i || !w_sent_q) state_d = SEND_W;
          else                         state_d = SEND_X;
        end
      end
      SEND_W: begin
        if (in_fire) begin
          if (widx_q == W_LAST) begin
            widx_d   = '0;
            w_sent_d = 1'b1;
            state_d  = SEND_X;
          end else begin
            widx_d = widx_q + 1'b1;
          end
        end
      end
      SEND_X: begin
        if (in_fire) begin
          if (xidx_q == X_LAST) begin
            xidx_d  = '0;
            state_d = COLLECT;
          end else begin
            xidx_d = xidx_q + 1'b1;
          end
        end
      end
      COLLECT: begin
        if (out_fire) begin
          guard_d = 1'b1;
          if (ridx_q == X_LAST) begin
            ridx_d  = '0;
            state_d = DONE;
          end else begin
            ridx_d = ridx_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      widx_q   <= '0;
      xidx_q   <= '0;
      ridx_q   <= '0;
      w_sent_q <= 1'b0;
      guard_q  <= 1'b0;
      for (int i = 0; i < SIZE_X; i++) res_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      widx_q   <= widx_d;
      xidx_q   <= xidx_d;
      ridx_q   <= ridx_d;
      w_sent_q <= w_sent_d;
      guard_q  <= guard_d;
      if (out_fire) res_q[ridx_q] <= mvm.out_data;
    end
  end

  // Operand buffers keep their contents across reset.
  always_ff @(posedge clk) begin
    if (cfg_wr_en_i && !busy_o) begin
      if (cfg_sel_i && (cfg_addr_i < 4'(SIZE_W)))
        w_buf_q[cfg_addr_i[WI-1:0]] <= cfg_data_i;
      if (!cfg_sel_i && (cfg_addr_i < 4'(SIZE_X)))
        x_buf_q[cfg_addr_i[XI-1:0]] <= cfg_data_i;
    end
  end
endmodule
